jbi_ncio_mto_ctl: RTL and testbench

//  Mondo timeout controller for the NCIO interrupt path. It sits upstream and

---
 rtl/jbi_ncio_mto_ctl.sv | 170 +++++++++++++++++
 tb/tb_jbi_ncio_mto_ctl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/jbi_ncio_mto_ctl.sv
// ----------------------------------------------------------------------------
// jbi_ncio_mto_ctl
//
// Mondo timeout controller for the NCIO interrupt path.
//   * A programmable prescaler produces the shared timeout_wrap tick that
//     every per-entry mondo timeout slice uses as its time base.
//   * The timeout_err pulses coming back from the slices are collected here.
//     The first failing entry is logged and offered to the JBI error/CSR
//     logic through a vld/ack handshake.
//   * A sticky overflow flag records errors that were lost while an earlier
//     error was still pending.
//   * A saturating counter tracks how many errors were logged.
//
// Ports
//   clk                  JBI clock
//   rst                  asynchronous active-high reset
//   csr_mto_en_i         timeout enable from CSR
//   csr_mto_interval_i   wrap period minus 1, in clk cycles
//   timeout_wrap_o       1-cycle tick to all slices
//   slice_err_i          timeout_err from each slice
//   err_vld_o            a logged error is pending
//   err_id_o             index of the logged slice
//   err_ack_i            consumer accepts the logged error
//   err_ovf_o            sticky: an error was lost while one was pending
//   ovf_clr_i            clears err_ovf_o
//   err_cnt_o            saturating count of logged errors
// ----------------------------------------------------------------------------
module jbi_ncio_mto_ctl #(
    parameter int NUM_SLICES = 16,
    parameter int ID_WIDTH   = 4,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_mto_en_i,
    input  logic [CNT_WIDTH-1:0]  csr_mto_interval_i,
    output logic                  timeout_wrap_o,
    input  logic [NUM_SLICES-1:0] slice_err_i,
    output logic                  err_vld_o,
    output logic [ID_WIDTH-1:0]   err_id_o,
    input  logic                  err_ack_i,
    output logic                  err_ovf_o,
    input  logic                  ovf_clr_i,
    output logic [7:0]            err_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    wrap_q, wrap_d;
    logic [ID_WIDTH-1:0]     err_id_q, err_id_d;
    logic                    err_ovf_q, err_ovf_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic [ID_WIDTH-1:0]     low_id;
    logic [NUM_SLICES-1:0]   low_mask;
    logic [NUM_SLICES-1:0]   held_mask;

    // Prescaler next state. The compare is ">=" rather than "==" so that
    // lowering the interval below the running count wraps on the very next
    // cycle instead of running all the way round the counter.
    always_comb begin
        cnt_d  = '0;
        wrap_d = 1'b0;
        if (csr_mto_en_i) begin
            if (cnt_q >= csr_mto_interval_i) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Priority encoder: lowest set slice_err bit wins. Scanning from the top
    // down lets the last assignment be the lowest index.
    always_comb begin
        low_id = '0;
        for (int i = NUM_SLICES - 1; i >= 0; i--) begin
            if (slice_err_i[i]) begin
                low_id = ID_WIDTH'(i);
            end
        end
    end

    // One-hot masks used to tell "other" error bits apart from the one that
    // is being captured now or is already held.
    assign low_mask  = NUM_SLICES'(1) << low_id;
    assign held_mask = NUM_SLICES'(1) << err_id_q;

    // Error FSM next state. A capture happens from IDLE, or from PEND in the
    // same cycle as the ack, so back-to-back errors see no bubble. Overflow
    // set takes priority over ovf_clr.
    always_comb begin
        logic ovf_set;
        state_d   = state_q;
        err_id_d  = err_id_q;
        err_cnt_d = err_cnt_q;
        ovf_set   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (slice_err_i != '0) begin
                    state_d  = PEND;
                    err_id_d = low_id;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    ovf_set = ((slice_err_i & ~low_mask) != '0);
                end
            end
            PEND: begin
                if (err_ack_i) begin
                    if (slice_err_i != '0) begin
                        err_id_d = low_id;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        ovf_set = ((slice_err_i & ~low_mask) != '0);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ovf_set = ((slice_err_i & ~held_mask) != '0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ovf_set) begin
            err_ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            err_ovf_d = 1'b0;
        end else begin
            err_ovf_d = err_ovf_q;
        end
    end

    // State register. Reset discards any pending error without needing an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wrap_q    <= 1'b0;
            err_id_q  <= '0;
            err_ovf_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            err_id_q  <= err_id_d;
            err_ovf_q <= err_ovf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign timeout_wrap_o = wrap_q;
    assign err_vld_o      = (state_q == PEND);
    assign err_id_o       = err_id_q;
    assign err_ovf_o      = err_ovf_q;
    assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_jbi_ncio_mto_ctl.sv
// ----------------------------------------------------------------------------
// tb_jbi_ncio_mto_ctl
//
// Directed testbench for jbi_ncio_mto_ctl. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled at the same point, so each
// applyStimulus call represents exactly one clock of the design.
// ----------------------------------------------------------------------------
module tb_jbi_ncio_mto_ctl;

    logic        clk;
    logic        rst;
    logic        csrMtoEn;
    logic [19:0] csrMtoInterval;
    logic        timeoutWrap;
    logic [15:0] sliceErr;
    logic        errVld;
    logic [3:0]  errId;
    logic        errAck;
    logic        errOvf;
    logic        ovfClr;
    logic [7:0]  errCnt;

    int checkCount;
    int errorCount;

    jbi_ncio_mto_ctl #(
        .NUM_SLICES (16),
        .ID_WIDTH   (4),
        .CNT_WIDTH  (20)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .csr_mto_en_i       (csrMtoEn),
        .csr_mto_interval_i (csrMtoInterval),
        .timeout_wrap_o     (timeoutWrap),
        .slice_err_i        (sliceErr),
        .err_vld_o          (errVld),
        .err_id_o           (errId),
        .err_ack_i          (errAck),
        .err_ovf_o          (errOvf),
        .ovf_clr_i          (ovfClr),
        .err_cnt_o          (errCnt)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs and advance one clock.
    task automatic applyStimulus(input logic en, input logic [19:0] interval,
                                 input logic [15:0] err, input logic ack,
                                 input logic clr);
        csrMtoEn       = en;
        csrMtoInterval = interval;
        sliceErr       = err;
        errAck         = ack;
        ovfClr         = clr;
        @(posedge clk);
        #1;
    endtask

    // Check the four error-side outputs in one go.
    task automatic checkErr(input string tag, input logic vld, input logic [3:0] id,
                            input logic ovf, input logic [7:0] cnt);
        checkOutput({tag, ".vld"}, 32'(errVld), 32'(vld));
        checkOutput({tag, ".id"},  32'(errId),  32'(id));
        checkOutput({tag, ".ovf"}, 32'(errOvf), 32'(ovf));
        checkOutput({tag, ".cnt"}, 32'(errCnt), 32'(cnt));
    endtask

    initial begin
        checkCount     = 0;
        errorCount     = 0;
        rst            = 1'b1;
        csrMtoEn       = 1'b0;
        csrMtoInterval = '0;
        sliceErr       = '0;
        errAck         = 1'b0;
        ovfClr         = 1'b0;

        #12;
        checkOutput("reset.wrap", 32'(timeoutWrap), 32'd0);
        checkErr("reset", 1'b0, 4'd0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // interval=4: wrap on every 5th clock after enabling.
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b1, 20'd4, 16'h0, 1'b0, 1'b0);
            checkOutput($sformatf("iv4.wrap%0d", k), 32'(timeoutWrap),
                        32'((k % 5) == 0));
        end
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 20'd4, 16'h0, 1'b0, 1'b0);
            checkOutput($sformatf("dis.wrap%0d", k), 32'(timeoutWrap), 32'd0);
        end
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 20'd4, 16'h0, 1'b0, 1'b0);
            checkOutput($sformatf("reen.wrap%0d", k), 32'(timeoutWrap), 32'(k == 5));
        end

        // interval=0: wrap every cycle.
        applyStimulus(1'b0, 20'd0, 16'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 20'd0, 16'h0, 1'b0, 1'b0);
            checkOutput($sformatf("iv0.wrap%0d", k), 32'(timeoutWrap), 32'd1);
        end

        // Count to 9 with interval 20, then drop the interval to 3.
        applyStimulus(1'b0, 20'd20, 16'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b1, 20'd20, 16'h0, 1'b0, 1'b0);
            checkOutput($sformatf("iv20.wrap%0d", k), 32'(timeoutWrap), 32'd0);
        end
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b1, 20'd3, 16'h0, 1'b0, 1'b0);
            checkOutput($sformatf("iv3.wrap%0d", k), 32'(timeoutWrap),
                        32'(k == 1 || k == 5 || k == 9));
        end
        applyStimulus(1'b0, 20'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("off.wrap", 32'(timeoutWrap), 32'd0);

        // Two simultaneous errors in IDLE: bit 3 logged, bit 5 overflows.
        applyStimulus(1'b0, 20'd0, 16'h0028, 1'b0, 1'b0);
        checkErr("cap28", 1'b1, 4'd3, 1'b1, 8'd1);
        applyStimulus(1'b0, 20'd0, 16'h0000, 1'b0, 1'b0);
        checkErr("hold", 1'b1, 4'd3, 1'b1, 8'd1);
        applyStimulus(1'b0, 20'd0, 16'h0000, 1'b0, 1'b1);
        checkErr("clr1", 1'b1, 4'd3, 1'b0, 8'd1);
        applyStimulus(1'b0, 20'd0, 16'h0008, 1'b0, 1'b0);
        checkErr("repeat3", 1'b1, 4'd3, 1'b0, 8'd1);
        applyStimulus(1'b0, 20'd0, 16'h0080, 1'b0, 1'b0);
        checkErr("other7", 1'b1, 4'd3, 1'b1, 8'd1);
        applyStimulus(1'b0, 20'd0, 16'h0000, 1'b1, 1'b0);
        checkErr("ack", 1'b0, 4'd3, 1'b1, 8'd1);
        applyStimulus(1'b0, 20'd0, 16'h0000, 1'b0, 1'b1);
        checkErr("clr2", 1'b0, 4'd3, 1'b0, 8'd1);
        applyStimulus(1'b0, 20'd0, 16'h0000, 1'b1, 1'b0);
        checkErr("ackIdle", 1'b0, 4'd3, 1'b0, 8'd1);

        // Ack together with a new error: no bubble, no overflow.
        applyStimulus(1'b0, 20'd0, 16'h0004, 1'b0, 1'b0);
        checkErr("cap2", 1'b1, 4'd2, 1'b0, 8'd2);
        applyStimulus(1'b0, 20'd0, 16'h0200, 1'b1, 1'b0);
        checkErr("ackNew9", 1'b1, 4'd9, 1'b0, 8'd3);
        applyStimulus(1'b0, 20'd0, 16'h0200, 1'b1, 1'b0);
        checkErr("ackSame9", 1'b1, 4'd9, 1'b0, 8'd4);
        applyStimulus(1'b0, 20'd0, 16'h0001, 1'b0, 1'b1);
        checkErr("setWins", 1'b1, 4'd9, 1'b1, 8'd4);
        applyStimulus(1'b0, 20'd0, 16'h0000, 1'b1, 1'b1);
        checkErr("ackClr", 1'b0, 4'd9, 1'b0, 8'd4);

        // Highest slice index.
        applyStimulus(1'b0, 20'd0, 16'h8000, 1'b0, 1'b0);
        checkErr("cap15", 1'b1, 4'd15, 1'b0, 8'd5);
        applyStimulus(1'b0, 20'd0, 16'h0000, 1'b1, 1'b0);
        checkErr("ack15", 1'b0, 4'd15, 1'b0, 8'd5);

        // 300 more serial errors: the count saturates at 255.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b0, 20'd0, 16'h0002, 1'b0, 1'b0);
            applyStimulus(1'b0, 20'd0, 16'h0000, 1'b1, 1'b0);
            if (k == 249) begin
                checkOutput("cnt255", 32'(errCnt), 32'd255);
            end
        end
        checkErr("sat", 1'b0, 4'd1, 1'b0, 8'd255);

        // Asynchronous reset while an error is pending and the tick is running.
        applyStimulus(1'b1, 20'd0, 16'h0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 20'd0, 16'h0000, 1'b0, 1'b1);
        checkErr("prerst", 1'b1, 4'd4, 1'b0, 8'd255);
        checkOutput("prerst.wrap", 32'(timeoutWrap), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst.wrap", 32'(timeoutWrap), 32'd0);
        checkErr("asyncRst", 1'b0, 4'd0, 1'b0, 8'd0);
        csrMtoEn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 20'd0, 16'h0000, 1'b1, 1'b0);
        checkErr("postRst", 1'b0, 4'd0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
